// File: rtl/mul_product_accumulator_if.sv
// Handshake bundle between the multiplier product bus, the product
// accumulator and its result consumer.
//   prod_in/in_valid/in_ready       : product input handshake
//   acc_out/cnt_out/ovf             : running / finished block result
//   out_valid/out_ready             : finished-block output handshake
// modport slave  : the accumulator side
// modport master : the producer/consumer side driving it
interface mul_product_accumulator_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic [7:0]       prod_in;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output prod_in, in_valid, out_ready,
    input  in_ready, acc_out, cnt_out, ovf, out_valid
  );

  modport slave (
    input  prod_in, in_valid, out_ready,
    output in_ready, acc_out, cnt_out, ovf, out_valid
  );
endinterface

// File: rtl/mul_product_accumulator.sv
// mul_product_accumulator
//   Sums BLOCK_LEN unsigned 8-bit products into an ACC_W-bit accumulator and
//   presents the finished sum (with sticky overflow flag) until consumed.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   ena      : design enable; low freezes all state except acc_clr
//   acc_clr  : synchronous clear of sum, count, flags and FSM
//   bus      : mul_product_accumulator_if.slave (product in / result out)
// Build option:
//   ACC_SATURATE_EN defined -> on carry-out acc sticks at all-ones
//   ACC_SATURATE_EN undefined -> acc wraps to its low ACC_W bits
module mul_product_accumulator #(
  parameter int ACC_W     = 16,
  parameter int CNT_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic                        acc_clr,
  mul_product_accumulator_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf, ovf_nxt;

  logic             in_ready;
  logic             accept;
  logic             last;
  logic [ACC_W:0]   sum;

  // in_ready depends only on state, ena and acc_clr, never on in_valid
  assign in_ready = ena & (state != HOLD) & ~acc_clr;
  assign accept   = bus.in_valid & in_ready;
  assign last     = (cnt == CNT_W'(BLOCK_LEN - 1));
  // one extra bit captures the carry-out for the overflow flag
  assign sum      = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, bus.prod_in};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    if (acc_clr) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end else if (state == HOLD) begin
      if (ena && bus.out_ready) begin
        state_nxt = IDLE;
        acc_nxt   = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
      end
    end else if (accept) begin
      cnt_nxt = cnt + 1'b1;
      if (sum[ACC_W]) begin
        ovf_nxt = 1'b1;
`ifdef ACC_SATURATE_EN
        acc_nxt = '1;
`else
        acc_nxt = sum[ACC_W-1:0];
`endif
      end else begin
        acc_nxt = sum[ACC_W-1:0];
      end
      // BLOCK_LEN==1 makes 'last' true from IDLE, going straight to HOLD
      state_nxt = last ? HOLD : ACCUM;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.acc_out   = acc;
  assign bus.cnt_out   = cnt;
  assign bus.ovf       = ovf;

endmodule
